// File: rtl/core_pkg.sv
// Shared types and constants for the unified-memory port arbiter of the rv32i core.
package core_pkg;
  localparam int ADDR_W_DFLT = 32;
  localparam int DATA_W_DFLT = 32;

  // Owner tags double as the port mux select values.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic {IDLE, RD_WAIT} arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port bundle; slave = arbiter view, master = requesters + memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = core_pkg::ADDR_W_DFLT,
  parameter int DATA_W = core_pkg::DATA_W_DFLT
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_sel;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_sel, mem_en, mem_we, mem_addr, mem_wdata, mem_be, stall_if
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_sel, mem_en, mem_we, mem_addr, mem_wdata, mem_be, stall_if
  );
endinterface

// File: rtl/mem_port_arbiter_lat.sv
// Loadable down-counter; expire marks the cycle read data is valid on the port.
module mem_lat_timer #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);
  localparam int CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)            cnt <= '0;
    else if (load)       cnt <= CW'(MEM_LAT);
    else if (cnt != '0)  cnt <= cnt - CW'(1);
  end

  assign expire = (cnt == CW'(1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for the single-ported unified memory, with
// bounded data streaks so fetch cannot starve, and latency-timed read return.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DFLT,
  parameter int DATA_W          = DATA_W_DFLT,
  parameter int MEM_LAT         = 1,
  parameter int MAX_DATA_STREAK = 2
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] MAX_S = 2'(MAX_DATA_STREAK);

  arb_state_t state, state_nxt;
  logic [1:0] streak;
  logic       owner, sel_q;
  logic       expire, rd_done, can_gnt, d_win, f_win, rd_gnt;

  mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk    (clk),
    .rst    (rst),
    .load   (rd_gnt),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Everything is qualified with rst so the cycle reset is asserted already
  // shows a quiet port, even before the registers have been cleared.
  always_comb begin
    state_nxt = state;
    rd_done   = 1'b0;
    can_gnt   = 1'b0;
    d_win     = 1'b0;
    f_win     = 1'b0;
    if (rst) begin
      rd_done = (state == RD_WAIT) && expire;
      can_gnt = (state == IDLE) || rd_done;
      d_win   = can_gnt && bus.d_req && (!bus.if_req || streak < MAX_S);
      f_win   = can_gnt && !d_win && bus.if_req;
    end
    rd_gnt = f_win || (d_win && !bus.d_we);
    if (rd_gnt)                          state_nxt = RD_WAIT;
    else if (state == RD_WAIT && !rd_done) state_nxt = RD_WAIT;
    else                                 state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      streak <= '0;
      owner  <= OWN_IF;
      sel_q  <= OWN_IF;
    end else begin
      if (rd_gnt)         owner <= d_win ? OWN_D : OWN_IF;
      if (d_win || f_win) sel_q <= d_win ? OWN_D : OWN_IF;
      if (!bus.if_req || f_win)      streak <= '0;
      else if (d_win && streak < MAX_S) streak <= streak + 2'd1;
    end
  end

  assign bus.if_gnt    = f_win;
  assign bus.d_gnt     = d_win;
  assign bus.mem_en    = d_win || f_win;
  assign bus.mem_we    = d_win && bus.d_we;
  assign bus.mem_sel   = !rst ? OWN_IF : (d_win ? OWN_D : (f_win ? OWN_IF : sel_q));
  assign bus.mem_addr  = d_win ? bus.d_addr : (f_win ? bus.if_addr : '0);
  assign bus.mem_wdata = d_win ? bus.d_wdata : '0;
  assign bus.mem_be    = d_win ? bus.d_be : (f_win ? '1 : '0);
  assign bus.stall_if  = rst && bus.if_req && !f_win;

  assign bus.if_rvalid = rd_done && (owner == OWN_IF);
  assign bus.d_rvalid  = rd_done && (owner == OWN_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: two arbiters (MEM_LAT 1 and 3) with a tiny memory model; read data
// expectations are queued when a request is presented and popped on rvalid.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b3 ();

  mem_port_arbiter #(.MEM_LAT(1), .MAX_DATA_STREAK(2)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_port_arbiter #(.MEM_LAT(3), .MAX_DATA_STREAK(2)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  // Memory returns addr ^ 0x83 for the last read issued (0x10 -> 0x93).
  logic [31:0] ra1 = '0, ra3 = '0;
  always @(posedge clk) begin
    if (b1.mem_en && !b1.mem_we) ra1 <= b1.mem_addr;
    if (b3.mem_en && !b3.mem_we) ra3 <= b3.mem_addr;
  end
  assign b1.mem_rdata = ra1 ^ 32'h83;
  assign b3.mem_rdata = ra3 ^ 32'h83;

  int n_chk = 0, n_err = 0;
  logic [31:0] q1i[$], q1d[$], q3i[$], q3d[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic nx; @(negedge clk); endtask
  task automatic px; @(posedge clk); #1; endtask

  function automatic logic [31:0] md(input logic [31:0] a);
    return a ^ 32'h83;
  endfunction

  // Scoreboard pop on every rvalid; an rvalid with nothing queued is an error.
  always @(negedge clk) begin
    if (b1.if_rvalid) begin
      if (q1i.size() == 0) chk("if1_spurious_rvalid", 1, 0);
      else chk("if1_rdata", b1.if_rdata, q1i.pop_front());
    end
    if (b1.d_rvalid) begin
      if (q1d.size() == 0) chk("d1_spurious_rvalid", 1, 0);
      else chk("d1_rdata", b1.d_rdata, q1d.pop_front());
    end
    if (b3.if_rvalid) begin
      if (q3i.size() == 0) chk("if3_spurious_rvalid", 1, 0);
      else chk("if3_rdata", b3.if_rdata, q3i.pop_front());
    end
    if (b3.d_rvalid) begin
      if (q3d.size() == 0) chk("d3_spurious_rvalid", 1, 0);
      else chk("d3_rdata", b3.d_rdata, q3d.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic isd;
    rst = 1'b0;
    b1.if_req = 1'b1; b1.if_addr = '0; b1.d_req = 1'b1; b1.d_we = 1'b0;
    b1.d_addr = '0; b1.d_wdata = '0; b1.d_be = '0;
    b3.if_req = 1'b1; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0;
    b3.d_addr = '0; b3.d_wdata = '0; b3.d_be = '0;

    // Reset state with requests pending
    px; px; nx;
    chk("rst_if_gnt", b1.if_gnt, 0);
    chk("rst_d_gnt", b1.d_gnt, 0);
    chk("rst_mem_en", b1.mem_en, 0);
    chk("rst_mem_we", b1.mem_we, 0);
    chk("rst_mem_sel", b1.mem_sel, 0);
    chk("rst_stall", b1.stall_if, 0);
    chk("rst_rvalid", {b1.if_rvalid, b1.d_rvalid}, 0);
    chk("rst3_if_gnt", b3.if_gnt, 0);
    px;
    b1.if_req = 1'b0; b1.d_req = 1'b0; b3.if_req = 1'b0;
    rst = 1'b1;

    // Lone fetch, MEM_LAT=1
    b1.if_req = 1'b1; b1.if_addr = 32'h10; q1i.push_back(md(32'h10));
    nx;
    chk("f_if_gnt", b1.if_gnt, 1);
    chk("f_mem_en", b1.mem_en, 1);
    chk("f_mem_sel", b1.mem_sel, 0);
    chk("f_mem_addr", b1.mem_addr, 32'h10);
    chk("f_mem_be", b1.mem_be, 4'hf);
    px; b1.if_req = 1'b0;
    nx;
    chk("f_if_rvalid", b1.if_rvalid, 1);
    chk("f_if_rdata", b1.if_rdata, 32'h93);
    chk("f_d_rvalid", b1.d_rvalid, 0);
    chk("f_idle_en", b1.mem_en, 0);
    px;

    // Streak: continuous fetch + load, expect D D IF D D IF
    b1.if_req = 1'b1; b1.if_addr = 32'h200; q1i.push_back(md(32'h200));
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h300; q1d.push_back(md(32'h300));
    for (int k = 0; k < 6; k++) begin
      isd = (k % 3 != 2);
      nx;
      chk($sformatf("s%0d_d_gnt", k), b1.d_gnt, isd);
      chk($sformatf("s%0d_if_gnt", k), b1.if_gnt, !isd);
      chk($sformatf("s%0d_stall", k), b1.stall_if, isd);
      chk($sformatf("s%0d_sel", k), b1.mem_sel, isd);
      px;
      if (k < 5) begin
        if (isd) begin b1.d_addr += 4; q1d.push_back(md(b1.d_addr)); end
        else     begin b1.if_addr += 4; q1i.push_back(md(b1.if_addr)); end
      end
    end
    b1.if_req = 1'b0;
    nx; chk("s_tail_d_gnt", b1.d_gnt, 1);
    px; b1.d_req = 1'b0;
    nx; px;

    // Store then fetch
    b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h100; b1.d_be = 4'b0011;
    b1.d_wdata = 32'hdeadbeef;
    b1.if_req = 1'b1; b1.if_addr = 32'h14; q1i.push_back(md(32'h14));
    nx;
    chk("st_d_gnt", b1.d_gnt, 1);
    chk("st_if_gnt", b1.if_gnt, 0);
    chk("st_mem_we", b1.mem_we, 1);
    chk("st_mem_be", b1.mem_be, 4'b0011);
    chk("st_mem_sel", b1.mem_sel, 1);
    chk("st_mem_addr", b1.mem_addr, 32'h100);
    chk("st_mem_wdata", b1.mem_wdata, 32'hdeadbeef);
    px; b1.d_req = 1'b0; b1.d_we = 1'b0;
    nx;
    chk("st_f_if_gnt", b1.if_gnt, 1);
    chk("st_f_mem_we", b1.mem_we, 0);
    chk("st_f_mem_be", b1.mem_be, 4'hf);
    chk("st_f_d_rvalid", b1.d_rvalid, 0);
    px; b1.if_req = 1'b0;
    nx; chk("st_d_rvalid_t2", b1.d_rvalid, 0);
    px;

    // MEM_LAT=3 load with fetch held
    b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 32'h400; q3d.push_back(md(32'h400));
    b3.if_req = 1'b1; b3.if_addr = 32'h20; q3i.push_back(md(32'h20));
    nx;
    chk("l3_d_gnt", b3.d_gnt, 1);
    chk("l3_stall_t0", b3.stall_if, 1);
    px; b3.d_req = 1'b0;
    for (int k = 1; k < 3; k++) begin
      nx;
      chk($sformatf("l3_if_gnt_t%0d", k), b3.if_gnt, 0);
      chk($sformatf("l3_stall_t%0d", k), b3.stall_if, 1);
      chk($sformatf("l3_d_rvalid_t%0d", k), b3.d_rvalid, 0);
      chk($sformatf("l3_sel_hold_t%0d", k), b3.mem_sel, 1);
      px;
    end
    nx;
    chk("l3_d_rvalid_t3", b3.d_rvalid, 1);
    chk("l3_d_rdata_t3", b3.d_rdata, md(32'h400));
    chk("l3_if_gnt_t3", b3.if_gnt, 1);
    chk("l3_stall_t3", b3.stall_if, 0);
    px; b3.if_req = 1'b0;
    nx; px; nx; px;
    nx; chk("l3_if_rvalid_t6", b3.if_rvalid, 1);
    px;

    // Reset in the middle of a MEM_LAT=3 read; its data must never return
    b3.d_req = 1'b1; b3.d_addr = 32'h500;
    b3.if_req = 1'b1; b3.if_addr = 32'h24; q3i.push_back(md(32'h24));
    nx; chk("rr_d_gnt", b3.d_gnt, 1);
    px; b3.d_req = 1'b0; rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nx;
      chk($sformatf("rr%0d_gnts", k), {b3.if_gnt, b3.d_gnt}, 0);
      chk($sformatf("rr%0d_en_we", k), {b3.mem_en, b3.mem_we}, 0);
      chk($sformatf("rr%0d_sel", k), b3.mem_sel, 0);
      chk($sformatf("rr%0d_rvalid", k), {b3.if_rvalid, b3.d_rvalid}, 0);
      chk($sformatf("rr%0d_stall", k), b3.stall_if, 0);
      px;
    end
    rst = 1'b1;
    nx;
    chk("rr_first_if_gnt", b3.if_gnt, 1);
    chk("rr_first_d_rvalid", b3.d_rvalid, 0);
    px; b3.if_req = 1'b0;
    for (int k = 0; k < 5; k++) begin nx; px; end

    chk("sb_drained", q1i.size() + q1d.size() + q3i.size() + q3d.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
